// File: rtl/mem_dump_scanner.sv
// Debug-read memory scanner. It sweeps a word-address range through the CPU
// debug read port. Each captured word leaves as a 5-byte record
// {addr, data[31:24], data[23:16], data[15:8], data[7:0]} on a valid/ready
// byte stream.
module mem_dump_scanner #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 63,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       ReadData,
  output logic              read_mem_en,
  output logic [ADDR_W-1:0] read_mem_addr,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);
  localparam logic [2:0]        LAT_LOAD  = 3'(READ_LAT - 1);
  localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        idx;
  logic [2:0]        cnt;
  logic [31:0]       data_q;
  logic [ADDR_W:0]   ws_q;
  logic              abort_pend;
  logic              xfer;
  logic              abort_eff;

  // Record counter never exceeds the number of words in the window.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == WORDS_MAX) ? v : v + (ADDR_W+1)'(1);
  endfunction

  // Byte 0 is the word address, bytes 1..4 the data word, MSB first.
  function automatic logic [7:0] byte_sel(input logic [2:0] i,
                                          input logic [ADDR_W-1:0] a,
                                          input logic [31:0] d);
    case (i)
      3'd0:    byte_sel = 8'(a);
      3'd1:    byte_sel = d[31:24];
      3'd2:    byte_sel = d[23:16];
      3'd3:    byte_sel = d[15:8];
      default: byte_sel = d[7:0];
    endcase
  endfunction

  assign xfer          = (state == S_SEND) && out_ready;
  assign abort_eff     = abort_pend || abort;
  assign read_mem_addr = read_mem_en ? addr : '0;
  assign out_data      = out_valid ? byte_sel(idx, addr, data_q) : 8'h00;
  assign words_sent    = ws_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_nxt   = state;
    read_mem_en = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_REQ;
      S_REQ: begin
        read_mem_en = 1'b1;
        state_nxt   = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        read_mem_en = 1'b1;
        if (abort)           state_nxt = S_IDLE;
        else if (cnt == 3'd0) state_nxt = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (xfer) begin
          if (abort_eff)        state_nxt = S_IDLE;
          else if (idx == 3'd4) state_nxt = (addr == END_A) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan control: address, latency countdown, byte index, record count, abort latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      idx        <= 3'd0;
      cnt        <= 3'd0;
      ws_q       <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start && !abort) begin
            addr <= START_A;
            ws_q <= '0;
          end
        end
        S_REQ: cnt <= LAT_LOAD;
        S_WAIT: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
          else             idx <= 3'd0;
        end
        S_SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (xfer) begin
            if (idx == 3'd4) begin
              ws_q <= sat_inc(ws_q);
              if (!abort_eff && addr != END_A) addr <= addr + ADDR_W'(1);
            end else begin
              idx <= idx + 3'd1;
            end
            if (abort_eff) abort_pend <= 1'b0;
          end
        end
        default: abort_pend <= 1'b0;
      endcase
    end
  end

  // Read-data capture once the port latency has elapsed.
  always_ff @(posedge clk) begin
    if (state == S_WAIT && cnt == 3'd0) data_q <= ReadData;
  end

endmodule
